// File: rtl/class_switch_n.sv
// N-class switching layer: steers each word into one of 2**CLASS_BITS FIFOs by its top bits.
// Optional feature macro: CLASS_SWITCH_DROPCNT_EN builds per-class saturating drop counters.
module class_switch_n #(
   parameter  int DATA_SIZE  = 10,
   parameter  int CLASS_BITS = 1,
   parameter  int FIFO_DEPTH = 8,
   parameter  int AF_LEVEL   = 6,
   parameter  int AE_LEVEL   = 2,
   localparam int NUM_CLASS  = 2**CLASS_BITS
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   input  logic [DATA_SIZE-1:0]           in,
   input  logic [NUM_CLASS-1:0]           pop,
   output logic [NUM_CLASS*DATA_SIZE-1:0] out_data,
   output logic [NUM_CLASS-1:0]           out_valid,
   output logic [NUM_CLASS-1:0]           fifo_empty,
   output logic [NUM_CLASS-1:0]           fifo_full,
   output logic [NUM_CLASS-1:0]           almost_empty,
   output logic [NUM_CLASS-1:0]           almost_full,
   output logic                           pause,
   output logic [NUM_CLASS-1:0]           fifo_error,
   output logic                           error,
   output logic [NUM_CLASS*8-1:0]         drop_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   logic [CLASS_BITS-1:0] in_class;
   assign in_class = in[DATA_SIZE-1 -: CLASS_BITS];

   for (genvar i = 0; i < NUM_CLASS; i++) begin : g_class
      localparam logic [CLASS_BITS-1:0] CLS_ID = CLASS_BITS'(i);

      logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
      logic [PW-1:0]        wr_ptr, rd_ptr;
      logic [CW-1:0]        count;
      logic [DATA_SIZE-1:0] rd_data;
      logic                 rd_valid, err_q;
      logic                 is_empty, is_full, push_req, do_push, do_pop, drop, underflow;

      assign is_empty  = (count == '0);
      assign is_full   = (count == DEPTH_C);
      assign push_req  = in_valid && (in_class == CLS_ID);
      // A full FIFO still accepts a push when the same cycle frees a slot.
      assign do_push   = push_req && (!is_full || pop[i]);
      assign do_pop    = pop[i] && !is_empty;
      assign drop      = push_req && is_full && !pop[i];
      assign underflow = pop[i] && is_empty;

      // NOTE: synchronous reset -- reset is only sampled at the clock edge, so it sits inside the edge-triggered block.
      always_ff @(posedge clk) begin
         if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err_q    <= 1'b0;
         end else begin
            rd_valid <= do_pop;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
               rd_ptr  <= rd_ptr + 1'b1;
               rd_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
            if (drop || underflow) err_q <= 1'b1;
         end
      end

      // NOTE: the storage array has no reset; the pointers and count alone define which entries are live.
      always_ff @(posedge clk) begin
         if (do_push) mem[wr_ptr] <= in;
      end

      assign out_data[i*DATA_SIZE +: DATA_SIZE] = rd_data;
      assign out_valid[i]    = rd_valid;
      assign fifo_error[i]   = err_q;
      assign fifo_empty[i]   = is_empty;
      assign fifo_full[i]    = is_full;
      assign almost_full[i]  = (count >= AF_C);
      assign almost_empty[i] = (count <= AE_C);

`ifdef CLASS_SWITCH_DROPCNT_EN
      logic [7:0] drop_cnt;
      always_ff @(posedge clk) begin
         if (!reset)                          drop_cnt <= '0;
         else if (drop && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 1'b1;
      end
      assign drop_count[i*8 +: 8] = drop_cnt;
`else
      assign drop_count[i*8 +: 8] = 8'h00;
`endif
   end

   assign pause = |almost_full;
   assign error = |fifo_error;

endmodule

// File: tb/tb_class_switch_n.sv
// Self-checking bench for class_switch_n: a default two-class instance driven from a vector
// table plus hand sequences, and a four-class depth-4 instance for routing and pointer wrap.
module tb_class_switch_n;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // default instance: 2 classes, depth 8, AF 6, AE 2
   logic        iv;
   logic [9:0]  din;
   logic [1:0]  pop;
   logic [19:0] od;
   logic [1:0]  ov, emp, ful, ae, af, fe;
   logic        pau, err;
   logic [15:0] dc;

   class_switch_n u_dut (
      .clk(clk), .reset(rst), .in_valid(iv), .in(din), .pop(pop),
      .out_data(od), .out_valid(ov), .fifo_empty(emp), .fifo_full(ful),
      .almost_empty(ae), .almost_full(af), .pause(pau), .fifo_error(fe),
      .error(err), .drop_count(dc)
   );

   // four-class instance, depth 4
   logic        iv4;
   logic [9:0]  din4;
   logic [3:0]  pop4;
   logic [39:0] od4;
   logic [3:0]  ov4, emp4, ful4, ae4, af4, fe4;
   logic        pau4, err4;
   logic [31:0] dc4;

   class_switch_n #(.DATA_SIZE(10), .CLASS_BITS(2), .FIFO_DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut4 (
      .clk(clk), .reset(rst), .in_valid(iv4), .in(din4), .pop(pop4),
      .out_data(od4), .out_valid(ov4), .fifo_empty(emp4), .fifo_full(ful4),
      .almost_empty(ae4), .almost_full(af4), .pause(pau4), .fifo_error(fe4),
      .error(err4), .drop_count(dc4)
   );

`ifdef CLASS_SWITCH_DROPCNT_EN
   localparam bit DROPCNT = 1'b1;
`else
   localparam bit DROPCNT = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic        iv;
      logic [9:0]  din;
      logic [1:0]  pop;
      logic [1:0]  ov;
      logic [19:0] od;
      logic [1:0]  emp, ful, ae, af;
      logic        pau;
      logic [1:0]  fe;
   } vec_t;

   function automatic vec_t v(logic r, logic i, logic [9:0] d, logic [1:0] p, logic [1:0] o,
                              logic [19:0] q, logic [1:0] e, logic [1:0] f, logic [1:0] a_e,
                              logic [1:0] a_f, logic pa, logic [1:0] er);
      vec_t t;
      t.rst = r; t.iv = i; t.din = d; t.pop = p; t.ov = o; t.od = q;
      t.emp = e; t.ful = f; t.ae = a_e; t.af = a_f; t.pau = pa; t.fe = er;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      logic [9:0] exp_w;
      iv = 0; din = '0; pop = '0;
      iv4 = 0; din4 = '0; pop4 = '0;

      //           rst iv din      pop ov od        emp ful ae af pau fe
      tbl.push_back(v(0, 0, 10'd0,  0, 0, 20'd0,    3, 0, 3, 0, 0, 0));
      tbl.push_back(v(0, 0, 10'd0,  0, 0, 20'd0,    3, 0, 3, 0, 0, 0));
      tbl.push_back(v(1, 1, 10'd0,  0, 0, 20'd0,    2, 0, 3, 0, 0, 0));
      tbl.push_back(v(1, 1, 10'd1,  0, 0, 20'd0,    2, 0, 3, 0, 0, 0));
      tbl.push_back(v(1, 1, 10'd2,  0, 0, 20'd0,    2, 0, 2, 0, 0, 0));
      tbl.push_back(v(1, 1, 10'd3,  0, 0, 20'd0,    2, 0, 2, 0, 0, 0));
      tbl.push_back(v(1, 1, 10'd4,  0, 0, 20'd0,    2, 0, 2, 0, 0, 0));
      tbl.push_back(v(1, 1, 10'd5,  0, 0, 20'd0,    2, 0, 2, 1, 1, 0));
      tbl.push_back(v(1, 1, 10'd6,  0, 0, 20'd0,    2, 0, 2, 1, 1, 0));
      tbl.push_back(v(1, 1, 10'd7,  0, 0, 20'd0,    2, 1, 2, 1, 1, 0));
      tbl.push_back(v(1, 1, 10'd8,  0, 0, 20'd0,    2, 1, 2, 1, 1, 1));
      tbl.push_back(v(1, 0, 10'd0,  1, 1, 20'd0,    2, 0, 2, 1, 1, 1));
      tbl.push_back(v(1, 0, 10'd0,  1, 1, 20'd1,    2, 0, 2, 1, 1, 1));
      tbl.push_back(v(1, 0, 10'd0,  1, 1, 20'd2,    2, 0, 2, 0, 0, 1));
      tbl.push_back(v(1, 0, 10'd0,  1, 1, 20'd3,    2, 0, 2, 0, 0, 1));
      tbl.push_back(v(1, 0, 10'd0,  1, 1, 20'd4,    2, 0, 2, 0, 0, 1));
      tbl.push_back(v(1, 0, 10'd0,  1, 1, 20'd5,    2, 0, 3, 0, 0, 1));
      tbl.push_back(v(1, 0, 10'd0,  1, 1, 20'd6,    2, 0, 3, 0, 0, 1));
      tbl.push_back(v(1, 0, 10'd0,  1, 1, 20'd7,    3, 0, 3, 0, 0, 1));
      tbl.push_back(v(1, 0, 10'd0,  2, 0, 20'd7,    3, 0, 3, 0, 0, 3));
      tbl.push_back(v(1, 1, 10'h200,2, 0, 20'd7,    1, 0, 3, 0, 0, 3));
      tbl.push_back(v(1, 0, 10'd0,  2, 2, 20'h80007,3, 0, 3, 0, 0, 3));
      tbl.push_back(v(1, 0, 10'd0,  0, 0, 20'h80007,3, 0, 3, 0, 0, 3));
      tbl.push_back(v(0, 0, 10'd0,  0, 0, 20'd0,    3, 0, 3, 0, 0, 0));

      foreach (tbl[i]) begin
         rst = tbl[i].rst; iv = tbl[i].iv; din = tbl[i].din; pop = tbl[i].pop;
         tick();
         check($sformatf("v%0d out_valid", i),    64'(ov),  64'(tbl[i].ov));
         check($sformatf("v%0d out_data", i),     64'(od),  64'(tbl[i].od));
         check($sformatf("v%0d fifo_empty", i),   64'(emp), 64'(tbl[i].emp));
         check($sformatf("v%0d fifo_full", i),    64'(ful), 64'(tbl[i].ful));
         check($sformatf("v%0d almost_empty", i), 64'(ae),  64'(tbl[i].ae));
         check($sformatf("v%0d almost_full", i),  64'(af),  64'(tbl[i].af));
         check($sformatf("v%0d pause", i),        64'(pau), 64'(tbl[i].pau));
         check($sformatf("v%0d fifo_error", i),   64'(fe),  64'(tbl[i].fe));
         check($sformatf("v%0d error", i),        64'(err), 64'(|tbl[i].fe));
         if (i == 10)
            check("v10 drop_count", 64'(dc), DROPCNT ? 64'h1 : 64'h0);
      end
      check("reset drop_count", 64'(dc), 64'h0);

      // full class 1 with simultaneous push and pop
      rst = 1; iv = 1; pop = 0;
      for (int k = 0; k < 8; k++) begin
         din = 10'h200 + 10'(k);
         tick();
      end
      check("c1 full", 64'(ful), 64'h2);
      din = 10'h2FF; pop = 2'b10;
      tick();
      check("c1 pp out_valid", 64'(ov), 64'h2);
      check("c1 pp out_data", 64'(od[19:10]), 64'h200);
      check("c1 pp still full", 64'(ful), 64'h2);
      check("c1 pp no error", 64'(fe), 64'h0);
      iv = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         exp_w = (k < 8) ? 10'h200 + 10'(k) : 10'h2FF;
         check($sformatf("c1 drain%0d", k), {63'(od[19:10]), ov[1]}, {63'(exp_w), 1'b1});
      end
      pop = 0;
      tick();
      check("c1 drained empty", 64'(emp), 64'h3);
      check("c1 drained ov", 64'(ov), 64'h0);

      // reset mid-operation discards stored words
      iv = 1; din = 10'h011;
      repeat (3) tick();
      check("mid fill", 64'(emp), 64'h2);
      iv = 0; rst = 0;
      tick();
      check("mid reset empty", 64'(emp), 64'h3);
      check("mid reset ov", 64'(ov), 64'h0);
      rst = 1; pop = 2'b01;
      tick();
      check("mid post-reset pop ov", 64'(ov), 64'h0);
      check("mid post-reset underflow", 64'(fe), 64'h1);
      pop = 0; rst = 0;
      tick();
      rst = 1;

      // drop-counter saturation on a full class 0
      iv = 1; din = 10'h055;
      repeat (8) tick();
      tick();
      check("sat first drop", 64'(dc), DROPCNT ? 64'h1 : 64'h0);
      repeat (299) tick();
      check("sat drop_count", 64'(dc), DROPCNT ? 64'hFF : 64'h0);
      check("sat fifo_error", 64'(fe), 64'h1);
      check("sat error", 64'(err), 64'h1);
      iv = 0;

      // four-class routing
      iv4 = 1;
      din4 = 10'h0AA; tick();
      din4 = 10'h1BB; tick();
      din4 = 10'h2CC; tick();
      din4 = 10'h3DD; tick();
      check("r4 not empty", 64'(emp4), 64'h0);
      iv4 = 0; pop4 = 4'hF;
      tick();
      check("r4 out_valid", 64'(ov4), 64'hF);
      check("r4 out_data", 64'(od4), 64'({10'h3DD, 10'h2CC, 10'h1BB, 10'h0AA}));
      check("r4 empty", 64'(emp4), 64'hF);
      check("r4 no error", 64'(fe4), 64'h0);
      pop4 = 0;
      tick();
      check("r4 ov clears", 64'(ov4), 64'h0);

      // pointer wrap: 20 push/pop pairs through depth-4 class 2
      iv4 = 1; din4 = 10'h200;
      tick();
      for (int k = 1; k < 20; k++) begin
         din4 = 10'h200 + 10'(k); pop4 = 4'b0100;
         tick();
         check($sformatf("wrap%0d", k), {63'(od4[29:20]), ov4[2]}, {63'(10'h200 + 10'(k - 1)), 1'b1});
      end
      iv4 = 0;
      tick();
      check("wrap last", {63'(od4[29:20]), ov4[2]}, {63'(10'h213), 1'b1});
      pop4 = 0;
      tick();
      check("wrap empty", 64'(emp4), 64'hF);
      check("wrap no error", 64'(fe4), 64'h0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/class_switch_n.md
# class_switch_n

Parametrised N-class switching layer for the adaptive PCIe switching datapath. It steers each incoming word into one of `2**CLASS_BITS` per-class FIFOs, selected by the word's top `CLASS_BITS` bits. It exports per-class watermark/status flags, a global pause for upstream flow control, and sticky per-class error flags. It is the generalised successor of the two-class switch, with configurable width, depth, class count and watermarks, plus drop-on-full semantics.

## Interface
- `DATA_SIZE`, 10, word width including class field
- `CLASS_BITS`, 1, class field width; `NUM_CLASS = 2**CLASS_BITS` (1..3 legal)
- `FIFO_DEPTH`, 8, entries per class FIFO; power of two, 4..64
- `AF_LEVEL`, 6, almost-full threshold (occupancy >= AF_LEVEL)
- `AE_LEVEL`, 2, almost-empty threshold (occupancy <= AE_LEVEL)
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `in_valid`  in  1  push strobe for `in`
- `in`  in  DATA_SIZE  data word; class = `in[DATA_SIZE-1 -: CLASS_BITS]`
- `pop`  in  NUM_CLASS  per-class read strobe
- `out_data`  out  NUM_CLASS*DATA_SIZE  packed per-class read data; class i at `[i*DATA_SIZE +: DATA_SIZE]`
- `out_valid`  out  NUM_CLASS  per-class one-cycle read-data qualifier
- `fifo_empty`, `fifo_full`, `almost_empty`, `almost_full`  out  NUM_CLASS each  per-class occupancy flags
- `pause`  out  1  OR of all `almost_full` bits
- `fifo_error`  out  NUM_CLASS  sticky per-class error
- `error`  out  1  OR of `fifo_error`
- `drop_count`  out  NUM_CLASS*8  per-class saturating drop counters (see Configuration)

## Operation
- Each class FIFO has a circular buffer with write/read pointers of log2(FIFO_DEPTH) bits. Pointers wrap modulo depth. Occupancy is a (log2(FIFO_DEPTH)+1)-bit count, range 0..FIFO_DEPTH.
- Push: if `in_valid` and the target class FIFO is not full, or is full with a same-cycle pop on that class, the word is written and the write pointer advances.
- Drop: if `in_valid` and the target FIFO is full with no same-cycle pop, the word is discarded and `fifo_error[class]` is set.
- Pop: if `pop[i]` and FIFO i is not empty, the head word is registered into `out_data[i]`, `out_valid[i]` is high next cycle, and the read pointer advances.
- Pop on empty: no pointer change, `out_valid[i]` stays 0, `out_data[i]` holds, and `fifo_error[i]` is set.
- Simultaneous push and pop on an empty FIFO: the pop is an underflow error. The push is stored; there is no fall-through.
- Simultaneous push and pop on a non-empty, non-full FIFO: occupancy is unchanged.
- Flags are decoded from the registered occupancy:
  - `fifo_empty` = count==0
  - `fifo_full` = count==FIFO_DEPTH
  - `almost_full` = count>=AF_LEVEL
  - `almost_empty` = count<=AE_LEVEL
- `fifo_error` bits are cleared only by reset. `pause` is advisory: upstream is expected to stop pushing, but the block never back-pressures beyond the drop rule.

## Timing
- On reset (`reset`=0 at an edge), the following values take effect from that edge:
  - pointers and counts 0
  - `out_data` 0, `out_valid` 0
  - `fifo_empty` all 1, `almost_empty` all 1
  - `fifo_full`, `almost_full`, `pause`, `fifo_error`, `error`, `drop_count` all 0
- Reset mid-operation discards all stored words with no output of pending data.
- Push latency: a word written at edge k is poppable at edge k+1. The `pop` sampled at edge k+1 gives `out_data`/`out_valid` valid after edge k+1.
- Flags and `pause` update in the cycle after the edge that changes occupancy; there is no extra register stage.
- `fifo_error` asserts after the offending edge. `error` is combinational OR.
- Minimum write-to-read latency through a class: 2 edges.

## Configuration
- `CLASS_SWITCH_DROPCNT_EN` defined:
  - each class keeps an 8-bit `drop_count` incremented on every dropped push
  - it saturates at 255 and clears on reset
- Undefined: no counters are built, and `drop_count` is tied to all zeros. All other behaviour is identical.

## Test plan
- Reset with defaults: hold `reset`=0 for 2 cycles → `fifo_empty`=2'b11, `almost_empty`=2'b11, all other outputs 0.
- Class routing with CLASS_BITS=2: push 10'h0AA, 10'h1BB, 10'h2CC, 10'h3DD, then pop all four → each `out_valid[i]` pulses once, delivering the word pushed to class i in the slot for class i.
- Fill and drop with defaults: 9 pushes to class 0 (values 0..8) → `almost_full[0]`=1 after the 6th push and `pause`=1. After the 8th push `fifo_full[0]`=1. The 9th push sets `fifo_error[0]` and `error`, and with the macro `drop_count[7:0]`=1. Eight pops return 0..7 in order.
- Full with simultaneous push+pop: class 1 full, push 10'h2FF with `pop[1]`=1 → oldest word is output, count stays 8, no error.
- Underflow: `pop[0]`=1 on empty → `out_valid[0]`=0, `fifo_error[0]`=1 sticky until reset. Pointer wrap check: 20 push/pop pairs with FIFO_DEPTH=4 → data order preserved.
- Drop saturation with macro defined: 300 pushes to a full class 0 → `drop_count[7:0]`=255.
